// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer: word fetches over a req/gnt/rvalid bus, split into
// little-endian halfwords and delivered one per cycle with valid/ready and a PC.
module ifu_prefetch_buf #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_valid,
    input  logic [31:0] branch_addr,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic [15:0] hw_out,
    output logic        hw_valid,
    input  logic        hw_ready,
    output logic [31:0] hw_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]    state;
    logic [29:0]   fetch_word;
    logic          skip_lo;
    logic          drop;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [30:0]   pc_hw;
    logic [15:0]   mem [DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] push_n;
    logic [CW-1:0] free;
    logic          room_ok;

    assign hw_valid = (count != '0);
    assign pop      = hw_valid && hw_ready && !branch_valid;
    // A branch in the same cycle as the return kills the word just like a pending drop.
    assign push     = (state == WAIT) && bus_rvalid && !drop && !branch_valid;
    assign push_n   = skip_lo ? CW'(1) : CW'(2);
    assign free     = CW'(DEPTH) - count;
    assign room_ok  = (free >= CW'(2));

    assign bus_req  = (state == REQ);
    assign bus_addr = {fetch_word, 2'b00};
    assign hw_pc    = {pc_hw, 1'b0};
    assign hw_out   = hw_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_word <= RESET_ADDR[31:2];
            skip_lo    <= RESET_ADDR[1];
            drop       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pc_hw      <= RESET_ADDR[31:1];
        end else begin
            case (state)
                IDLE: if (!branch_valid && room_ok) state <= REQ;
                REQ: begin
                    if (bus_gnt) begin
                        state <= WAIT;
                        drop  <= branch_valid;
                    end else if (branch_valid) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (branch_valid) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (branch_valid) begin
                fetch_word <= branch_addr[31:2];
                skip_lo    <= branch_addr[1];
                pc_hw      <= branch_addr[31:1];
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
            end else begin
                if (push) begin
                    fetch_word <= fetch_word + 30'd1;
                    skip_lo    <= 1'b0;
                    wr_ptr     <= wr_ptr + AW'(push_n);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    pc_hw  <= pc_hw + 31'd1;
                end
                count <= count + (push ? push_n : CW'(0)) - (pop ? CW'(1) : CW'(0));
            end
        end
    end

    // Storage needs no reset: hw_out is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_lo) begin
                mem[wr_ptr] <= bus_rdata[31:16];
            end else begin
                mem[wr_ptr]          <= bus_rdata[15:0];
                mem[wr_ptr + AW'(1)] <= bus_rdata[31:16];
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Cycle-by-cycle vector table for ifu_prefetch_buf (RESET_ADDR=0x100, DEPTH=8),
// followed by a hand-written asynchronous-reset-mid-WAIT sequence.
module tb_ifu_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [15:0] hw_out;
    logic        hw_valid;
    logic        hw_ready = 1'b0;
    logic [31:0] hw_pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifu_prefetch_buf #(.DEPTH(8), .RESET_ADDR(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .branch_valid(branch_valid), .branch_addr(branch_addr),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .hw_out(hw_out), .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_pc(hw_pc)
    );

    typedef struct {
        logic        rst, br;
        logic [31:0] baddr;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [15:0] eout;
        logic [31:0] epc;
        int          ecnt;
    } vec_t;

    localparam int NV = 44;
    vec_t vec [NV];

    function automatic vec_t mk(logic r, logic b, logic [31:0] ba, logic g, logic v,
                                logic [31:0] d, logic y, logic eq, logic [31:0] ea,
                                logic ev, logic [15:0] eo, logic [31:0] ep, int ec);
        vec_t t;
        t.rst = r; t.br = b; t.baddr = ba; t.gnt = g; t.rv = v; t.rdata = d; t.rdy = y;
        t.ereq = eq; t.eaddr = ea; t.evld = ev; t.eout = eo; t.epc = ep; t.ecnt = ec;
        return t;
    endfunction

    task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic chk_outs(int step, logic eq, logic [31:0] ea, logic ev,
                            logic [15:0] eo, logic [31:0] ep, int ec);
        chk("bus_req", step, 32'(bus_req), 32'(eq));
        chk("bus_addr", step, bus_addr, ea);
        chk("hw_valid", step, 32'(hw_valid), 32'(ev));
        if (ev) chk("hw_out", step, 32'(hw_out), 32'(eo));
        chk("hw_pc", step, hw_pc, ep);
        chk("count", step, 32'(dut.count), 32'(ec));
    endtask

    initial begin
        // reset state, then first fetch and delivery
        vec[0]  = mk(0,0,0,        0,0,32'h0,        0, 0,32'h100,0,16'h0,   32'h100,0);
        vec[1]  = mk(1,0,0,        0,0,32'h0,        1, 0,32'h100,0,16'h0,   32'h100,0);
        vec[2]  = mk(1,0,0,        1,0,32'h0,        1, 1,32'h100,0,16'h0,   32'h100,0);
        vec[3]  = mk(1,0,0,        0,1,32'hBBBBAAAA, 1, 0,32'h100,0,16'h0,   32'h100,0);
        vec[4]  = mk(1,0,0,        0,0,32'h0,        1, 0,32'h104,1,16'hAAAA,32'h100,2);
        vec[5]  = mk(1,0,0,        0,0,32'h0,        1, 1,32'h104,1,16'hBBBB,32'h102,1);
        vec[6]  = mk(0,0,0,        0,0,32'h0,        0, 1,32'h104,0,16'h0,   32'h104,0);
        // fill to full with hw_ready=0, bus always granting/returning
        vec[7]  = mk(1,0,0,        0,0,32'h0,        0, 0,32'h100,0,16'h0,   32'h100,0);
        vec[8]  = mk(1,0,0,        1,1,32'h11110000, 0, 1,32'h100,0,16'h0,   32'h100,0);
        vec[9]  = mk(1,0,0,        1,1,32'h01020100, 0, 0,32'h100,0,16'h0,   32'h100,0);
        vec[10] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 0,32'h104,1,16'h0100,32'h100,2);
        vec[11] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 1,32'h104,1,16'h0100,32'h100,2);
        vec[12] = mk(1,0,0,        1,1,32'h01060104, 0, 0,32'h104,1,16'h0100,32'h100,2);
        vec[13] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 0,32'h108,1,16'h0100,32'h100,4);
        vec[14] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 1,32'h108,1,16'h0100,32'h100,4);
        vec[15] = mk(1,0,0,        1,1,32'h010A0108, 0, 0,32'h108,1,16'h0100,32'h100,4);
        vec[16] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 0,32'h10C,1,16'h0100,32'h100,6);
        vec[17] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 1,32'h10C,1,16'h0100,32'h100,6);
        vec[18] = mk(1,0,0,        1,1,32'h010E010C, 0, 0,32'h10C,1,16'h0100,32'h100,6);
        vec[19] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 0,32'h110,1,16'h0100,32'h100,8);
        vec[20] = mk(1,0,0,        1,1,32'hFFFFFFFF, 1, 0,32'h110,1,16'h0100,32'h100,8);
        vec[21] = mk(1,0,0,        1,1,32'hFFFFFFFF, 1, 0,32'h110,1,16'h0102,32'h102,7);
        vec[22] = mk(1,0,0,        1,1,32'hFFFFFFFF, 0, 0,32'h110,1,16'h0104,32'h104,6);
        vec[23] = mk(1,0,0,        1,0,32'h0,        0, 1,32'h110,1,16'h0104,32'h104,6);
        // push of 2 with a pop at count 6, then branch colliding with push and pop
        vec[24] = mk(1,0,0,        0,1,32'h01120110, 1, 0,32'h110,1,16'h0104,32'h104,6);
        vec[25] = mk(1,0,0,        0,0,32'h0,        1, 0,32'h114,1,16'h0106,32'h106,7);
        vec[26] = mk(1,0,0,        0,0,32'h0,        0, 0,32'h114,1,16'h0108,32'h108,6);
        vec[27] = mk(1,0,0,        1,0,32'h0,        0, 1,32'h114,1,16'h0108,32'h108,6);
        vec[28] = mk(1,1,32'h401,  0,1,32'h01160114, 1, 0,32'h114,1,16'h0108,32'h108,6);
        vec[29] = mk(1,0,0,        0,0,32'h0,        1, 0,32'h400,0,16'h0,   32'h400,0);
        // branch during WAIT, return discarded
        vec[30] = mk(1,0,0,        1,0,32'h0,        1, 1,32'h400,0,16'h0,   32'h400,0);
        vec[31] = mk(1,1,32'h300,  0,0,32'h0,        1, 0,32'h400,0,16'h0,   32'h400,0);
        vec[32] = mk(1,0,0,        0,1,32'hDEADBEEF, 1, 0,32'h300,0,16'h0,   32'h300,0);
        vec[33] = mk(1,0,0,        0,0,32'h0,        1, 0,32'h300,0,16'h0,   32'h300,0);
        // odd-halfword target: withdrawn request, idle branch, upper half only
        vec[34] = mk(1,1,32'h207,  0,0,32'h0,        1, 1,32'h300,0,16'h0,   32'h300,0);
        vec[35] = mk(1,1,32'h207,  0,0,32'h0,        1, 0,32'h204,0,16'h0,   32'h206,0);
        vec[36] = mk(1,0,0,        0,0,32'h0,        1, 0,32'h204,0,16'h0,   32'h206,0);
        vec[37] = mk(1,0,0,        1,0,32'h0,        1, 1,32'h204,0,16'h0,   32'h206,0);
        vec[38] = mk(1,0,0,        0,1,32'h22221111, 0, 0,32'h204,0,16'h0,   32'h206,0);
        vec[39] = mk(1,0,0,        0,0,32'h0,        1, 0,32'h208,1,16'h2222,32'h206,1);
        // branch in the same cycle as a grant: return dropped
        vec[40] = mk(1,1,32'h500,  1,0,32'h0,        1, 1,32'h208,0,16'h0,   32'h208,0);
        vec[41] = mk(1,0,0,        0,1,32'h12345678, 1, 0,32'h500,0,16'h0,   32'h500,0);
        vec[42] = mk(1,0,0,        0,0,32'h0,        1, 0,32'h500,0,16'h0,   32'h500,0);
        vec[43] = mk(1,0,0,        1,0,32'h0,        0, 1,32'h500,0,16'h0,   32'h500,0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk_outs(i, vec[i].ereq, vec[i].eaddr, vec[i].evld, vec[i].eout, vec[i].epc, vec[i].ecnt);
            rst          = vec[i].rst;
            branch_valid = vec[i].br;
            branch_addr  = vec[i].baddr;
            bus_gnt      = vec[i].gnt;
            bus_rvalid   = vec[i].rv;
            bus_rdata    = vec[i].rdata;
            hw_ready     = vec[i].rdy;
        end

        // In WAIT for 0x500: return a word, then reset asynchronously in the next WAIT
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hAAAA5555;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk_outs(100, 1'b0, 32'h504, 1'b1, 16'h5555, 32'h500, 2);
        @(negedge clk);
        chk_outs(101, 1'b1, 32'h504, 1'b1, 16'h5555, 32'h500, 2);
        bus_gnt = 1'b1;
        @(posedge clk);
        #3;
        bus_gnt = 1'b0;
        chk("pre_reset_vld", 102, 32'(hw_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk_outs(103, 1'b0, 32'h100, 1'b0, 16'h0, 32'h100, 0);
        @(negedge clk);
        rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk_outs(104, 1'b1, 32'h100, 1'b0, 16'h0, 32'h100, 0);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h02020201;
        chk_outs(105, 1'b0, 32'h100, 1'b0, 16'h0, 32'h100, 0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk_outs(106, 1'b0, 32'h104, 1'b1, 16'h0201, 32'h100, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch_buf.md
Name: ifu_prefetch_buf

Overview:
Instruction prefetch buffer sitting directly upstream of the Thumb instruction fetch/assembly stage. It issues word-aligned fetches on a simple request/grant/return bus. It splits each returned 32-bit word into little-endian halfwords, queues them in a halfword FIFO, and presents one halfword per cycle with a valid/ready handshake. Branch redirects flush the queue, discard any in-flight return, and restart fetch at the target, including odd-halfword targets.

Parameters:
DEPTH, 8, FIFO capacity in halfwords; power of two, >= 4.
RESET_ADDR, 32'h0000_0000, first fetch address after reset; halfword-aligned.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
branch_valid  input  1  redirect request, one-cycle pulse
branch_addr  input  32  redirect target; bit 0 ignored
bus_req  output  1  fetch request
bus_addr  output  32  word-aligned fetch address; stable while bus_req=1
bus_gnt  input  1  request accepted when sampled with bus_req=1
bus_rvalid  input  1  read data return, one cycle per accepted request
bus_rdata  input  32  returned word; [15:0] is the lower address
hw_out  output  16  FIFO head halfword
hw_valid  output  1  hw_out valid (count != 0)
hw_ready  input  1  consumer accepts head when hw_valid=1
hw_pc  output  32  byte address of hw_out

Behaviour:
- Reset (rst=0, asynchronous):
  - bus_req=0, bus_addr={RESET_ADDR[31:2],2'b00}.
  - skip_lo=RESET_ADDR[1].
  - hw_valid=0, count=0, hw_out=0.
  - hw_pc={RESET_ADDR[31:1],1'b0}, state=IDLE, drop=0.
  - Reset mid-transaction abandons it; a later bus_rvalid outside WAIT is ignored.
- FSM states: IDLE, REQ, WAIT. At most one outstanding request.
  - IDLE -> REQ when (DEPTH-count) >= 2 and branch_valid=0. bus_req rises on the next cycle.
  - REQ: bus_req=1, bus_addr held. On bus_gnt=1 -> WAIT and bus_req=0 the following cycle.
  - WAIT: on bus_rvalid=1:
    - If drop=0, push the halfwords, then set fetch_addr+=4 and skip_lo=0.
    - Always return to IDLE and clear drop.
    - Result: one-cycle bubble between requests.
- Push: write bus_rdata[15:0] then [31:16]; count+=2. If skip_lo=1, write only [31:16]; count+=1.
- Pop: when hw_valid && hw_ready, advance the head; count-=1; hw_pc+=2.
  - Simultaneous push and pop gives count += pushed-1.
  - Room check before issuing guarantees no overflow. Full (count=DEPTH) blocks new requests only.
- Empty: hw_valid=0. hw_out is don't-care, hw_pc holds.
- Pointers wrap modulo DEPTH. Address arithmetic wraps modulo 2^32.
- Branch (branch_valid=1), takes priority over everything in the same cycle:
  - count=0, pointers reset, and any same-cycle pop or push is discarded.
  - fetch_addr={branch_addr[31:2],2'b00}, skip_lo=branch_addr[1], hw_pc={branch_addr[31:1],1'b0}.
  - IDLE -> IDLE.
  - REQ with bus_gnt=0: request withdrawn, bus_req=0 next cycle, -> IDLE.
  - REQ with bus_gnt=1 same cycle: -> WAIT with drop=1.
  - WAIT without rvalid: drop=1, stay WAIT.
  - WAIT with rvalid same cycle: data discarded, -> IDLE.
  - A new request issues at the earliest one cycle after the branch.
- bus_rvalid outside WAIT: ignored.
- All outputs registered; push-to-hw_valid latency is one cycle.

Test Plan:
1. RESET_ADDR=0x100, release rst, gnt and rvalid respond in 1 cycle with 0xBBBBAAAA, hw_ready=1 -> bus_addr=0x100; then hw_out=0xAAAA with hw_pc=0x100, then hw_out=0xBBBB with hw_pc=0x102.
2. hw_ready=0, bus always grants/returns -> requests at 0x100, 0x104, 0x108, 0x10C; count=8; bus_req stays 0. Then one pop plus another pop -> request at 0x110.
3. branch_addr=0x207 while idle, return 0x2222_1111 -> bus_addr=0x204; only hw_out=0x2222 with hw_pc=0x206 is delivered; next fetch 0x208.
4. Branch to 0x300 during WAIT, then rvalid with 0xDEADBEEF -> word discarded, hw_valid stays 0, next bus_addr=0x300.
5. count=6 with push of 2 and pop in the same cycle -> count=7. Branch in the same cycle as a push and pop -> count=0, hw_pc=target.
6. Assert rst mid-WAIT, asynchronously between edges -> bus_req=0 and hw_valid=0 immediately. A stray rvalid after release is ignored; first request goes to RESET_ADDR.
